l2_miss_queue: RTL
==================

// Module: l2_miss_queue
// PURPOSE
//   Buffers line-fill requests that the L1 instruction and data caches send to
//   the next-level cache, and presents them to L2 one at a time over a
//   valid/ready handshake. Sits between the L1 add_out outputs and the L2 input.
//   Read requests to a line already queued are merged, so L2 sees one fill per
//   line. Merge and overflow events are counted for the statistics module.
// PARAMETERS
//   DEPTH     8   queue entries (power of 2, >=2)
//   ADDR_W    26  request address width (matches L1 add_out)
//   LINE_OFF  6   low address bits ignored for line match (64-byte line)
// PORTS
//   clk       in   1       rising-edge clock
//   rst_n     in   1       synchronous active-low reset
//   flush     in   1       synchronous clear of all queued entries
//   ic_valid  in   1       I-cache miss request this cycle (always a read)
//   ic_addr   in   ADDR_W  I-cache request address
//   dc_valid  in   1       D-cache miss request this cycle
//   dc_addr   in   ADDR_W  D-cache request address
//   dc_write  in   1       D-cache request is a write (1) or a read (0)
//   l2_valid  out  1       head entry valid toward L2
//   l2_addr   out  ADDR_W  head entry address
//   l2_write  out  1       head entry is a write
//   l2_src    out  1       head entry source: 0=IC, 1=DC
//   l2_ready  in   1       L2 accepts head this cycle
//   count     out  log2(DEPTH)+1  number of occupied entries
//   full      out  1       count==DEPTH
//   empty     out  1       count==0
//   drops     out  32      requests lost because the queue was full (saturating)
//   merges    out  32      requests merged into an existing entry (saturating)
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): queue empty, l2_valid=0, l2_addr/l2_write/l2_src=0,
//     count=0, empty=1, full=0, drops=0, merges=0. All inputs ignored that cycle.
//   - Circular buffer: head/tail pointers, DEPTH entries of {addr,write,src}.
//     l2_* come directly from head entry registers. l2_valid=!empty.
//   - Pop: l2_valid&&l2_ready at posedge removes head. l2_addr/l2_write/l2_src
//     hold stable while l2_valid=1 and l2_ready=0.
//   - Latency: a request into an empty queue gives l2_valid=1 on the next cycle.
//   - Per-cycle order: (1) pop, (2) DC request, (3) IC request. A slot freed by a
//     pop is available to a push in the same cycle.
//   - Line match: addr[ADDR_W-1:LINE_OFF] equal. Match candidates: entries still
//     present after the pop, plus the DC entry pushed this cycle (for IC only).
//   - Merge: a read request (IC, or DC with dc_write=0) that line-matches any
//     candidate is not stored and increments merges. Writes never merge.
//   - Push: an unmerged request takes the tail if space remains. Otherwise it is
//     dropped and drops increments. Two drops in one cycle add 2.
//   - full/empty/count reflect the registered state after the edge.
//   - Counters saturate at 32'hFFFF_FFFF and never wrap.
//   - Pointers wrap modulo DEPTH, with no bubble at wrap.
//   - flush=1: queue empties next cycle (l2_valid=0). Pops and requests in that
//     cycle are discarded and not counted. drops/merges are kept.
//   - rst_n=0 overrides flush and everything else, including an in-flight head.
// TESTING
//   1 reset, then DC write 0x0000040 -> next cycle l2_valid=1, l2_addr=0x0000040,
//     l2_write=1, l2_src=1, count=1.
//   2 same cycle: IC 0x0001000 and DC read 0x0001020 (same line), l2_ready=0 ->
//     one entry (src=1), merges=1, count=1.
//   3 l2_ready=0, fill 8 distinct IC lines, then IC+DC distinct the next cycle ->
//     full=1, drops=2. Then l2_ready=1 for 8 cycles -> FIFO order, empty=1.
//   4 queue full with l2_ready=1 and a new IC request in the same cycle -> pop and
//     push both happen, count stays 8, drops unchanged.
//   5 12 push/pop cycles to cross the pointer wrap -> addresses out in order,
//     with no gaps in l2_valid.
//   6 3 entries queued, flush=1 with an IC request -> empty next cycle, no drop or
//     merge counted. Also rst_n=0 mid-stall -> all outputs return to reset values.

Source files
------------

// File: rtl/l2_miss_queue_if.sv
// L1-to-L2 miss request bus: two request ports in, one valid/ready fill port out,
// plus occupancy and statistics. The queue sits on the slave side.
interface l2_miss_queue_if #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 26
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              flush;
    logic              ic_valid;
    logic [ADDR_W-1:0] ic_addr;
    logic              dc_valid;
    logic [ADDR_W-1:0] dc_addr;
    logic              dc_write;
    logic              l2_valid;
    logic [ADDR_W-1:0] l2_addr;
    logic              l2_write;
    logic              l2_src;
    logic              l2_ready;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic [31:0]       drops;
    logic [31:0]       merges;

    modport master (
        output flush, ic_valid, ic_addr, dc_valid, dc_addr, dc_write, l2_ready,
        input  l2_valid, l2_addr, l2_write, l2_src, count, full, empty, drops, merges
    );

    modport slave (
        input  flush, ic_valid, ic_addr, dc_valid, dc_addr, dc_write, l2_ready,
        output l2_valid, l2_addr, l2_write, l2_src, count, full, empty, drops, merges
    );
endinterface

// File: rtl/l2_miss_queue.sv
// Circular miss queue between the L1 caches and L2. Reads to an already queued
// line merge; requests arriving while full are dropped and counted.
module l2_miss_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned ADDR_W   = 26,
    parameter int unsigned LINE_OFF = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    l2_miss_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DEPTH-1:0]  r_write;
    logic [DEPTH-1:0]  r_src;
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic [31:0]       r_drops;
    logic [31:0]       r_merges;

    logic [PW-1:0]    w_off [DEPTH];
    logic [DEPTH-1:0] w_live;
    logic             w_pop;
    logic [CW-1:0]    w_free;
    logic             w_dc_hit;
    logic             w_ic_hit;
    logic             w_dc_push;
    logic             w_dc_drop;
    logic             w_dc_merge;
    logic             w_ic_push;
    logic             w_ic_drop;
    logic             w_ic_merge;
    logic [PW-1:0]    w_ic_slot;
    logic [1:0]       w_n_push;
    logic [1:0]       w_n_drop;
    logic [1:0]       w_n_merge;

    function automatic logic [31:0] sat_add(input logic [31:0] v, input logic [1:0] inc);
        logic [32:0] s;
        s = {1'b0, v} + {31'b0, inc};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic logic same_line(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return a[ADDR_W-1:LINE_OFF] == b[ADDR_W-1:LINE_OFF];
    endfunction

    always_comb begin
        w_pop    = (r_count != '0) && bus.l2_ready;
        w_dc_hit = 1'b0;
        w_ic_hit = 1'b0;
        // An entry is a match candidate only if it survives this cycle's pop.
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_off[i]  = PW'(i) - r_head;
            w_live[i] = ({1'b0, w_off[i]} < r_count) && !(w_pop && (w_off[i] == '0));
            if (w_live[i] && same_line(bus.dc_addr, r_addr[i])) w_dc_hit = 1'b1;
            if (w_live[i] && same_line(bus.ic_addr, r_addr[i])) w_ic_hit = 1'b1;
        end
        w_dc_hit = w_dc_hit && !bus.dc_write;
        w_free   = CW'(DEPTH) - r_count + CW'(w_pop);

        w_dc_merge = bus.dc_valid && w_dc_hit;
        w_dc_push  = bus.dc_valid && !w_dc_hit && (w_free != '0);
        w_dc_drop  = bus.dc_valid && !w_dc_hit && (w_free == '0);

        // IC also merges into the DC entry pushed in the same cycle.
        w_ic_hit   = w_ic_hit || (w_dc_push && same_line(bus.ic_addr, bus.dc_addr));
        w_ic_merge = bus.ic_valid && w_ic_hit;
        w_ic_push  = bus.ic_valid && !w_ic_hit && (w_free > CW'(w_dc_push));
        w_ic_drop  = bus.ic_valid && !w_ic_hit && !(w_free > CW'(w_dc_push));
        w_ic_slot  = r_tail + PW'(w_dc_push);

        w_n_push  = {1'b0, w_dc_push} + {1'b0, w_ic_push};
        w_n_drop  = {1'b0, w_dc_drop} + {1'b0, w_ic_drop};
        w_n_merge = {1'b0, w_dc_merge} + {1'b0, w_ic_merge};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
            end
            r_write  <= '0;
            r_src    <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_drops  <= '0;
            r_merges <= '0;
        end else if (bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_dc_push) begin
                r_addr[r_tail]  <= bus.dc_addr;
                r_write[r_tail] <= bus.dc_write;
                r_src[r_tail]   <= 1'b1;
            end
            if (w_ic_push) begin
                r_addr[w_ic_slot]  <= bus.ic_addr;
                r_write[w_ic_slot] <= 1'b0;
                r_src[w_ic_slot]   <= 1'b0;
            end
            r_head   <= r_head + PW'(w_pop);
            r_tail   <= r_tail + PW'(w_n_push);
            r_count  <= r_count - CW'(w_pop) + CW'(w_n_push);
            r_drops  <= sat_add(r_drops, w_n_drop);
            r_merges <= sat_add(r_merges, w_n_merge);
        end
    end

    assign bus.l2_valid = (r_count != '0);
    assign bus.l2_addr  = r_addr[r_head];
    assign bus.l2_write = r_write[r_head];
    assign bus.l2_src   = r_src[r_head];
    assign bus.count    = r_count;
    assign bus.full     = (r_count == CW'(DEPTH));
    assign bus.empty    = (r_count == '0);
    assign bus.drops    = r_drops;
    assign bus.merges   = r_merges;
endmodule
